// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg
// Shared definitions for the SSD1306 SPI command decoder:
//   - SSD1306 opcode constants that the decoder recognises
//   - addressing-mode and command-FSM state encodings
//   - skip_len():    number of ignored argument bytes for known multi-byte commands
//   - decode_mode(): maps the 0x20 argument onto a stored addressing mode
package ssd1306_pkg;

    // Commands that change decoder state
    localparam logic [7:0] OP_MEM_MODE      = 8'h20;
    localparam logic [7:0] OP_COL_ADDR      = 8'h21;
    localparam logic [7:0] OP_PAGE_ADDR     = 8'h22;
    localparam logic [7:0] OP_CONTRAST      = 8'h81;
    localparam logic [7:0] OP_SEG_REMAP0    = 8'hA0;
    localparam logic [7:0] OP_SEG_REMAP1    = 8'hA1;
    localparam logic [7:0] OP_DISP_NORMAL   = 8'hA6;
    localparam logic [7:0] OP_DISP_INVERT   = 8'hA7;
    localparam logic [7:0] OP_DISP_OFF      = 8'hAE;
    localparam logic [7:0] OP_DISP_ON       = 8'hAF;
    localparam logic [7:0] OP_COM_SCAN_NORM = 8'hC0;
    localparam logic [7:0] OP_COM_SCAN_REV  = 8'hC8;

    // Commands whose arguments are parsed but have no effect on the emulator
    localparam logic [7:0] OP_H_SCROLL_R    = 8'h26;
    localparam logic [7:0] OP_H_SCROLL_L    = 8'h27;
    localparam logic [7:0] OP_VH_SCROLL_R   = 8'h29;
    localparam logic [7:0] OP_VH_SCROLL_L   = 8'h2A;
    localparam logic [7:0] OP_CHARGE_PUMP   = 8'h8D;
    localparam logic [7:0] OP_VSCROLL_AREA  = 8'hA3;
    localparam logic [7:0] OP_MUX_RATIO     = 8'hA8;
    localparam logic [7:0] OP_DISP_OFFSET   = 8'hD3;
    localparam logic [7:0] OP_CLK_DIV       = 8'hD5;
    localparam logic [7:0] OP_PRECHARGE     = 8'hD9;
    localparam logic [7:0] OP_COM_PINS      = 8'hDA;
    localparam logic [7:0] OP_VCOMH         = 8'hDB;

    typedef enum logic [1:0] {
        MODE_HORIZ = 2'd0,
        MODE_VERT  = 2'd1,
        MODE_PAGE  = 2'd2
    } addr_mode_t;

    typedef enum logic [1:0] {
        ST_OPCODE,
        ST_ARG1,
        ST_ARG2,
        ST_SKIP
    } cmd_state_t;

    // Zero means "not a skipped multi-byte command"
    function automatic logic [2:0] skip_len(input logic [7:0] op);
        case (op)
            OP_CHARGE_PUMP, OP_MUX_RATIO, OP_DISP_OFFSET, OP_CLK_DIV,
            OP_PRECHARGE, OP_COM_PINS, OP_VCOMH:      skip_len = 3'd1;
            OP_VSCROLL_AREA:                          skip_len = 3'd2;
            OP_VH_SCROLL_R, OP_VH_SCROLL_L:           skip_len = 3'd5;
            OP_H_SCROLL_R, OP_H_SCROLL_L:             skip_len = 3'd6;
            default:                                  skip_len = 3'd0;
        endcase
    endfunction

    // Encoding 3 is invalid on the real part; it behaves as page mode
    function automatic addr_mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'd0:    decode_mode = MODE_HORIZ;
            2'd1:    decode_mode = MODE_VERT;
            default: decode_mode = MODE_PAGE;
        endcase
    endfunction

endpackage

// File: rtl/ssd1306_spi_cmd_dec_if.sv
// ssd1306_spi_cmd_dec_if
// The 4-wire SPI bus the emulated MCU drives towards the OLED, plus the
// OLED reset pin.
//   ss       chip select, active low
//   scl      SPI clock, mode 0
//   mosi     serial data, MSB first
//   dc       0 = command byte, 1 = data byte
//   oled_rst display reset, active low
// master: the MCU side (drives everything); slave: the decoder.
interface ssd1306_spi_cmd_dec_if;
    logic ss;
    logic scl;
    logic mosi;
    logic dc;
    logic oled_rst;

    modport master (output ss, scl, mosi, dc, oled_rst);
    modport slave  (input  ss, scl, mosi, dc, oled_rst);
endinterface

// File: rtl/ssd1306_spi_byte_rx.sv
// ssd1306_spi_byte_rx
// Brings the asynchronous SPI pins into the clk domain and assembles bytes.
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   ss/scl/mosi/dc    raw SPI pins
//   oled_rst          raw display reset pin (active low)
//   rx_byte           last complete byte (MSB first on the wire)
//   rx_dc             dc level sampled with bit 0 of that byte
//   byte_valid        one-cycle pulse, rx_byte/rx_dc are valid while high
//   oled_rst_s        synchronized oled_rst; low acts as a soft reset
module ssd1306_spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss,
    input  logic       scl,
    input  logic       mosi,
    input  logic       dc,
    input  logic       oled_rst,
    output logic [7:0] rx_byte,
    output logic       rx_dc,
    output logic       byte_valid,
    output logic       oled_rst_s
);

    logic [SYNC_STAGES-1:0] ss_q, scl_q, mosi_q, dc_q, orst_q;
    logic                   scl_prev;
    logic [2:0]             bit_cnt;
    logic [6:0]             shift;
    logic                   ss_s, scl_s, mosi_s, dc_s, scl_rise;

    // oled_rst resets to "asserted" so that leaving rst looks exactly like
    // leaving a display reset; ss resets to "deselected".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_q     <= '1;
            scl_q    <= '0;
            mosi_q   <= '0;
            dc_q     <= '0;
            orst_q   <= '0;
            scl_prev <= 1'b0;
        end else begin
            ss_q     <= {ss_q[SYNC_STAGES-2:0], ss};
            scl_q    <= {scl_q[SYNC_STAGES-2:0], scl};
            mosi_q   <= {mosi_q[SYNC_STAGES-2:0], mosi};
            dc_q     <= {dc_q[SYNC_STAGES-2:0], dc};
            orst_q   <= {orst_q[SYNC_STAGES-2:0], oled_rst};
            scl_prev <= scl_q[SYNC_STAGES-1];
        end
    end

    assign ss_s       = ss_q[SYNC_STAGES-1];
    assign scl_s      = scl_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_q[SYNC_STAGES-1];
    assign dc_s       = dc_q[SYNC_STAGES-1];
    assign oled_rst_s = orst_q[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_prev & ~ss_s;

    // Deselecting the chip drops any partial byte so the next transfer
    // starts byte-aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt    <= 3'd0;
            shift      <= 7'd0;
            rx_byte    <= 8'd0;
            rx_dc      <= 1'b0;
            byte_valid <= 1'b0;
        end else if (!oled_rst_s) begin
            bit_cnt    <= 3'd0;
            shift      <= 7'd0;
            rx_byte    <= 8'd0;
            rx_dc      <= 1'b0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (ss_s) begin
                bit_cnt <= 3'd0;
            end else if (scl_rise) begin
                shift   <= {shift[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_byte    <= {shift, mosi_s};
                    rx_dc      <= dc_s;
                    byte_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ssd1306_spi_cmd_dec.sv
// ssd1306_spi_cmd_dec
// Decodes the SSD1306 SPI stream into display-state registers and
// framebuffer write strobes with SSD1306 auto-increment addressing.
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   spi                 SPI bus + oled_rst (slave modport)
//   fb_addr/fb_data     framebuffer write address (page*X_SIZE+col) and byte
//   fb_wr               one-cycle write strobe
//   fb_busy             power-on clear sweep in progress
//   display_on, invert, seg_remap, com_scan_rev, contrast, start_line
//                       display state for the renderer
// Build option: SSD1306_SPI_FB_CLEAR_EN adds a zero-fill sweep of the whole
// framebuffer after every rst / oled_rst release.
module ssd1306_spi_cmd_dec
    import ssd1306_pkg::*;
#(
    parameter int X_SIZE      = 128,
    parameter int Y_SIZE      = 64,
    parameter int FB_ADDR_W   = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    ssd1306_spi_cmd_dec_if.slave spi,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [7:0]           fb_data,
    output logic                 fb_wr,
    output logic                 fb_busy,
    output logic                 display_on,
    output logic                 invert,
    output logic                 seg_remap,
    output logic                 com_scan_rev,
    output logic [7:0]           contrast,
    output logic [5:0]           start_line
);

    localparam int PAGES  = Y_SIZE / 8;
    localparam int COL_W  = $clog2(X_SIZE);
    localparam int PAGE_W = $clog2(PAGES);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(X_SIZE - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);

    typedef struct packed {
        logic              display_on;
        logic              invert;
        logic              seg_remap;
        logic              com_scan_rev;
        logic [7:0]        contrast;
        logic [5:0]        start_line;
        addr_mode_t        mode;
        logic [COL_W-1:0]  col;
        logic [COL_W-1:0]  col_start;
        logic [COL_W-1:0]  col_end;
        logic [PAGE_W-1:0] page;
        logic [PAGE_W-1:0] page_start;
        logic [PAGE_W-1:0] page_end;
        cmd_state_t        fsm;
        logic [7:0]        op;
        logic [2:0]        skip_cnt;
    } dec_regs_t;

    localparam dec_regs_t REGS_RESET = '{
        display_on:   1'b0,
        invert:       1'b0,
        seg_remap:    1'b0,
        com_scan_rev: 1'b0,
        contrast:     8'h7F,
        start_line:   6'd0,
        mode:         MODE_PAGE,
        col:          '0,
        col_start:    '0,
        col_end:      COL_LAST,
        page:         '0,
        page_start:   '0,
        page_end:     PAGE_LAST,
        fsm:          ST_OPCODE,
        op:           8'h00,
        skip_cnt:     3'd0
    };

    logic [7:0]           rx_byte;
    logic                 rx_dc;
    logic                 byte_valid;
    logic                 oled_rst_s;
    dec_regs_t            r;
    logic                 clr_busy;
    logic [FB_ADDR_W-1:0] clr_addr;
    logic [FB_ADDR_W-1:0] ptr_addr;

    ssd1306_spi_byte_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_byte_rx (
        .clk        (clk),
        .rst        (rst),
        .ss         (spi.ss),
        .scl        (spi.scl),
        .mosi       (spi.mosi),
        .dc         (spi.dc),
        .oled_rst   (spi.oled_rst),
        .rx_byte    (rx_byte),
        .rx_dc      (rx_dc),
        .byte_valid (byte_valid),
        .oled_rst_s (oled_rst_s)
    );

    // Next pointer after a data byte. A window with start > end never hits
    // its end in the upper range, so the physical edge also wraps to start.
    logic              col_wrap, page_wrap;
    logic [COL_W-1:0]  col_inc, col_adv, col_set;
    logic [PAGE_W-1:0] page_inc, page_adv;
    logic [7:0]        col_byte, nib_col;

    always_comb begin
        col_wrap  = (r.col == r.col_end) || (r.col == COL_LAST);
        page_wrap = (r.page == r.page_end) || (r.page == PAGE_LAST);
        col_inc   = col_wrap ? r.col_start : r.col + 1'b1;
        page_inc  = page_wrap ? r.page_start : r.page + 1'b1;
        col_adv   = r.col;
        page_adv  = r.page;
        case (r.mode)
            MODE_HORIZ: begin
                col_adv = col_inc;
                if (col_wrap) page_adv = page_inc;
            end
            MODE_VERT: begin
                page_adv = page_inc;
                if (page_wrap) col_adv = col_inc;
            end
            default: col_adv = col_inc;
        endcase

        // 0x0X replaces the low column nibble, 0x1X the high one
        col_byte = 8'(r.col);
        nib_col  = rx_byte[4] ? {rx_byte[3:0], col_byte[3:0]}
                              : {col_byte[7:4], rx_byte[3:0]};
        col_set  = (nib_col > 8'(X_SIZE - 1)) ? COL_LAST : nib_col[COL_W-1:0];
    end

    // Command FSM and pointer. Data bytes are handled in any FSM state and
    // never consume a pending argument.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= REGS_RESET;
        end else if (!oled_rst_s) begin
            r <= REGS_RESET;
        end else if (byte_valid && !clr_busy) begin
            if (rx_dc) begin
                r.col  <= col_adv;
                r.page <= page_adv;
            end else begin
                case (r.fsm)
                    ST_OPCODE: begin
                        r.op <= rx_byte;
                        if (rx_byte[7:5] == 3'b000) begin
                            // Nibble column commands only apply in page mode
                            if (r.mode == MODE_PAGE) r.col <= col_set;
                        end else if (rx_byte[7:6] == 2'b01) begin
                            r.start_line <= rx_byte[5:0];
                        end else if (rx_byte[7:3] == 5'b10110) begin
                            r.page <= rx_byte[PAGE_W-1:0];
                        end else begin
                            case (rx_byte)
                                OP_DISP_ON:       r.display_on   <= 1'b1;
                                OP_DISP_OFF:      r.display_on   <= 1'b0;
                                OP_DISP_INVERT:   r.invert       <= 1'b1;
                                OP_DISP_NORMAL:   r.invert       <= 1'b0;
                                OP_SEG_REMAP1:    r.seg_remap    <= 1'b1;
                                OP_SEG_REMAP0:    r.seg_remap    <= 1'b0;
                                OP_COM_SCAN_REV:  r.com_scan_rev <= 1'b1;
                                OP_COM_SCAN_NORM: r.com_scan_rev <= 1'b0;
                                OP_MEM_MODE, OP_CONTRAST,
                                OP_COL_ADDR, OP_PAGE_ADDR: r.fsm <= ST_ARG1;
                                default: begin
                                    if (skip_len(rx_byte) != 3'd0) begin
                                        r.fsm      <= ST_SKIP;
                                        r.skip_cnt <= skip_len(rx_byte);
                                    end
                                end
                            endcase
                        end
                    end
                    ST_ARG1: begin
                        r.fsm <= ST_OPCODE;
                        case (r.op)
                            OP_MEM_MODE: r.mode     <= decode_mode(rx_byte[1:0]);
                            OP_CONTRAST: r.contrast <= rx_byte;
                            OP_COL_ADDR: begin
                                r.col_start <= rx_byte[COL_W-1:0];
                                r.fsm       <= ST_ARG2;
                            end
                            OP_PAGE_ADDR: begin
                                r.page_start <= rx_byte[PAGE_W-1:0];
                                r.fsm        <= ST_ARG2;
                            end
                            default: ;
                        endcase
                    end
                    ST_ARG2: begin
                        r.fsm <= ST_OPCODE;
                        if (r.op == OP_COL_ADDR) begin
                            r.col_end <= rx_byte[COL_W-1:0];
                            r.col     <= r.col_start;
                        end else begin
                            r.page_end <= rx_byte[PAGE_W-1:0];
                            r.page     <= r.page_start;
                        end
                    end
                    default: begin
                        r.skip_cnt <= r.skip_cnt - 3'd1;
                        if (r.skip_cnt <= 3'd1) r.fsm <= ST_OPCODE;
                    end
                endcase
            end
        end
    end

`ifdef SSD1306_SPI_FB_CLEAR_EN
    localparam logic [FB_ADDR_W-1:0] CLR_LAST = FB_ADDR_W'(X_SIZE * PAGES - 1);
    logic clr_armed;

    // Armed while any reset is held; the first free cycle starts the sweep,
    // which writes one zero byte per cycle up to the last address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_armed <= 1'b1;
            clr_busy  <= 1'b0;
            clr_addr  <= '0;
        end else if (!oled_rst_s) begin
            clr_armed <= 1'b1;
            clr_busy  <= 1'b0;
            clr_addr  <= '0;
        end else if (clr_armed) begin
            clr_armed <= 1'b0;
            clr_busy  <= 1'b1;
            clr_addr  <= '0;
        end else if (clr_busy) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == CLR_LAST) clr_busy <= 1'b0;
        end
    end
`else
    assign clr_busy = 1'b0;
    assign clr_addr = '0;
`endif

    assign ptr_addr = FB_ADDR_W'(r.page) * FB_ADDR_W'(X_SIZE) + FB_ADDR_W'(r.col);

    assign fb_busy      = clr_busy;
    assign fb_wr        = clr_busy | (byte_valid & rx_dc & oled_rst_s);
    assign fb_addr      = clr_busy ? clr_addr : ptr_addr;
    assign fb_data      = clr_busy ? 8'h00 : rx_byte;
    assign display_on   = r.display_on;
    assign invert       = r.invert;
    assign seg_remap    = r.seg_remap;
    assign com_scan_rev = r.com_scan_rev;
    assign contrast     = r.contrast;
    assign start_line   = r.start_line;

endmodule

// File: tb/tb_ssd1306_spi_cmd_dec.sv
// tb_ssd1306_spi_cmd_dec
// Directed self-checking bench for ssd1306_spi_cmd_dec. Drives SPI bytes
// through the interface, logs every framebuffer write at the falling clock
// edge and compares against hand-computed addresses and state values.
// Honours SSD1306_SPI_FB_CLEAR_EN for the expected clear-sweep length.
module tb_ssd1306_spi_cmd_dec;

`ifdef SSD1306_SPI_FB_CLEAR_EN
    localparam int EXP_CLR = 1024;
`else
    localparam int EXP_CLR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;
    logic       fb_wr, fb_busy, display_on, invert, seg_remap, com_scan_rev;
    logic [7:0] contrast;
    logic [5:0] start_line;

    int n_checks = 0;
    int n_fails  = 0;

    logic [9:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         busy_cycles = 0;
    int         clr_writes  = 0;
    int         clr_bad     = 0;
    logic [9:0] clr_expect  = '0;

    always #5 clk = ~clk;

    ssd1306_spi_cmd_dec_if spi_if ();

    ssd1306_spi_cmd_dec dut (
        .clk          (clk),
        .rst          (rst),
        .spi          (spi_if),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_wr        (fb_wr),
        .fb_busy      (fb_busy),
        .display_on   (display_on),
        .invert       (invert),
        .seg_remap    (seg_remap),
        .com_scan_rev (com_scan_rev),
        .contrast     (contrast),
        .start_line   (start_line)
    );

    // Write logger: sweep writes are tallied, ordinary writes are queued
    always @(negedge clk) begin
        if (fb_busy === 1'b1) busy_cycles++;
        if (fb_wr === 1'b1 && fb_busy === 1'b1) begin
            clr_writes++;
            if (fb_addr !== clr_expect || fb_data !== 8'h00) clr_bad++;
            clr_expect++;
        end else if (fb_wr === 1'b1) begin
            wr_addr_q.push_back(fb_addr);
            wr_data_q.push_back(fb_data);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic is_data);
        @(negedge clk);
        spi_if.ss = 1'b0;
        spi_if.dc = is_data;
        repeat (2) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            spi_if.mosi = b[i];
            repeat (3) @(negedge clk);
            spi_if.scl = 1'b1;
            repeat (4) @(negedge clk);
            spi_if.scl = 1'b0;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (fb_busy === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_checks++; n_fails++;
            $display("[TB] FAIL sweep_timeout: fb_busy still %b after %0d cycles, required 0", fb_busy, n);
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (fb_wr !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_fb_wr: got %b expected 0", fb_wr); end
        n_checks++; if (fb_addr !== 10'd0) begin n_fails++; $display("[TB] FAIL rst_fb_addr: got %h expected 000", fb_addr); end
        n_checks++; if (fb_data !== 8'd0) begin n_fails++; $display("[TB] FAIL rst_fb_data: got %h expected 00", fb_data); end
        n_checks++; if (fb_busy !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_fb_busy: got %b expected 0", fb_busy); end
        n_checks++; if (contrast !== 8'h7F) begin n_fails++; $display("[TB] FAIL rst_contrast: got %h expected 7f", contrast); end
        n_checks++; if ({display_on, invert, seg_remap, com_scan_rev} !== 4'b0000) begin n_fails++; $display("[TB] FAIL rst_flags: got %b expected 0000", {display_on, invert, seg_remap, com_scan_rev}); end
        n_checks++; if (start_line !== 6'd0) begin n_fails++; $display("[TB] FAIL rst_start_line: got %h expected 00", start_line); end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        wait_idle();
        repeat (2) @(negedge clk);
        n_checks++; if (clr_writes !== EXP_CLR) begin n_fails++; $display("[TB] FAIL por_sweep_writes: got %0d expected %0d", clr_writes, EXP_CLR); end
        clear_log();
    endtask

    task automatic test_page_mode_data();
        logic [9:0] exp_a [2];
        logic [7:0] exp_d [2];
        exp_a = '{10'h000, 10'h001};
        exp_d = '{8'hAA, 8'h55};
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        n_checks++; if (wr_addr_q.size() != 2) begin n_fails++; $display("[TB] FAIL page_wr_count: got %0d expected 2", wr_addr_q.size()); end
        for (int i = 0; i < 2; i++) if (i < wr_addr_q.size()) begin
            n_checks++;
            if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== exp_d[i]) begin
                n_fails++; $display("[TB] FAIL page_wr%0d: got %h/%h expected %h/%h", i, wr_addr_q[i], wr_data_q[i], exp_a[i], exp_d[i]);
            end
        end
        clear_log();
    endtask

    task automatic test_addr_window();
        logic [9:0] exp_a [3];
        logic [7:0] exp_d [3];
        exp_a = '{10'h1FE, 10'h1FF, 10'h27E};
        exp_d = '{8'h11, 8'h22, 8'h33};
        send_byte(8'h20, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h21, 1'b0); send_byte(8'h7E, 1'b0); send_byte(8'h7F, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(exp_d[i], 1'b1);
        n_checks++; if (wr_addr_q.size() != 3) begin n_fails++; $display("[TB] FAIL window_wr_count: got %0d expected 3", wr_addr_q.size()); end
        for (int i = 0; i < 3; i++) if (i < wr_addr_q.size()) begin
            n_checks++;
            if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== exp_d[i]) begin
                n_fails++; $display("[TB] FAIL window_wr%0d: got %h/%h expected %h/%h", i, wr_addr_q[i], wr_data_q[i], exp_a[i], exp_d[i]);
            end
        end
        clear_log();
    endtask

    task automatic test_contrast_flags();
        send_byte(8'h81, 1'b0); send_byte(8'h33, 1'b0);
        send_byte(8'hAF, 1'b0); send_byte(8'hA7, 1'b0);
        send_byte(8'hA1, 1'b0); send_byte(8'h65, 1'b0);
        n_checks++; if (contrast !== 8'h33) begin n_fails++; $display("[TB] FAIL contrast: got %h expected 33", contrast); end
        n_checks++; if (display_on !== 1'b1) begin n_fails++; $display("[TB] FAIL display_on: got %b expected 1", display_on); end
        n_checks++; if (invert !== 1'b1) begin n_fails++; $display("[TB] FAIL invert: got %b expected 1", invert); end
        n_checks++; if (seg_remap !== 1'b1) begin n_fails++; $display("[TB] FAIL seg_remap: got %b expected 1", seg_remap); end
        n_checks++; if (start_line !== 6'h25) begin n_fails++; $display("[TB] FAIL start_line: got %h expected 25", start_line); end
        n_checks++; if (wr_addr_q.size() != 0) begin n_fails++; $display("[TB] FAIL cmd_no_write: got %0d writes expected 0", wr_addr_q.size()); end
        clear_log();
    endtask

    task automatic test_skip();
        logic [7:0] args [6];
        args = '{8'hA6, 8'hA0, 8'hC8, 8'h7F, 8'h00, 8'h81};
        send_byte(8'hAE, 1'b0);
        n_checks++; if (display_on !== 1'b0) begin n_fails++; $display("[TB] FAIL display_off: got %b expected 0", display_on); end
        send_byte(8'h26, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(args[i], 1'b0);
        send_byte(8'hAF, 1'b0);
        n_checks++; if (display_on !== 1'b1) begin n_fails++; $display("[TB] FAIL skip_display_on: got %b expected 1", display_on); end
        n_checks++; if ({invert, seg_remap, com_scan_rev} !== 3'b110) begin n_fails++; $display("[TB] FAIL skip_flags: got %b expected 110", {invert, seg_remap, com_scan_rev}); end
        n_checks++; if (start_line !== 6'h25 || contrast !== 8'h33) begin n_fails++; $display("[TB] FAIL skip_regs: got %h/%h expected 25/33", start_line, contrast); end
        n_checks++; if (wr_addr_q.size() != 0) begin n_fails++; $display("[TB] FAIL skip_no_write: got %0d writes expected 0", wr_addr_q.size()); end
        clear_log();
    endtask

    task automatic test_partial_byte();
        @(negedge clk);
        spi_if.ss = 1'b0;
        spi_if.dc = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            spi_if.mosi = 1'b1;
            repeat (3) @(negedge clk);
            spi_if.scl = 1'b1;
            repeat (4) @(negedge clk);
            spi_if.scl = 1'b0;
        end
        repeat (2) @(negedge clk);
        spi_if.ss = 1'b1;
        repeat (6) @(negedge clk);
        send_byte(8'hC8, 1'b0);
        n_checks++; if (com_scan_rev !== 1'b1) begin n_fails++; $display("[TB] FAIL partial_com_scan: got %b expected 1", com_scan_rev); end
        n_checks++; if (wr_addr_q.size() != 0) begin n_fails++; $display("[TB] FAIL partial_no_write: got %0d writes expected 0", wr_addr_q.size()); end
        clear_log();
    endtask

    task automatic test_data_during_arg_skip();
        send_byte(8'h81, 1'b0);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h44, 1'b0);
        n_checks++; if (contrast !== 8'h44) begin n_fails++; $display("[TB] FAIL arg_contrast: got %h expected 44", contrast); end
        send_byte(8'hA8, 1'b0);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h3F, 1'b0);
        send_byte(8'hA6, 1'b0);
        n_checks++; if (invert !== 1'b0) begin n_fails++; $display("[TB] FAIL skip_then_invert: got %b expected 0", invert); end
        n_checks++; if (wr_addr_q.size() != 2) begin n_fails++; $display("[TB] FAIL mid_cmd_wr_count: got %0d expected 2", wr_addr_q.size()); end
        if (wr_addr_q.size() >= 2) begin
            n_checks++; if (wr_addr_q[0] !== 10'h27F || wr_data_q[0] !== 8'h5A) begin n_fails++; $display("[TB] FAIL mid_arg_wr: got %h/%h expected 27f/5a", wr_addr_q[0], wr_data_q[0]); end
            n_checks++; if (wr_addr_q[1] !== 10'h1FE || wr_data_q[1] !== 8'h3C) begin n_fails++; $display("[TB] FAIL mid_skip_wr: got %h/%h expected 1fe/3c", wr_addr_q[1], wr_data_q[1]); end
        end
        clear_log();
    endtask

    task automatic test_oled_reset();
        send_byte(8'h21, 1'b0);
        send_byte(8'h10, 1'b0);
        busy_cycles = 0; clr_writes = 0; clr_bad = 0; clr_expect = '0;
        @(negedge clk);
        spi_if.oled_rst = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++; if (contrast !== 8'h7F || display_on !== 1'b0) begin n_fails++; $display("[TB] FAIL oled_rst_hold: got %h/%b expected 7f/0", contrast, display_on); end
        n_checks++; if (fb_wr !== 1'b0 || fb_addr !== 10'd0) begin n_fails++; $display("[TB] FAIL oled_rst_fb: got %b/%h expected 0/000", fb_wr, fb_addr); end
        spi_if.oled_rst = 1'b1;
        repeat (5) @(negedge clk);
        wait_idle();
        repeat (2) @(negedge clk);
        n_checks++; if (busy_cycles !== EXP_CLR) begin n_fails++; $display("[TB] FAIL sweep_busy_cycles: got %0d expected %0d", busy_cycles, EXP_CLR); end
        n_checks++; if (clr_writes !== EXP_CLR) begin n_fails++; $display("[TB] FAIL sweep_writes: got %0d expected %0d", clr_writes, EXP_CLR); end
        n_checks++; if (clr_bad !== 0) begin n_fails++; $display("[TB] FAIL sweep_order: got %0d bad writes expected 0", clr_bad); end
        n_checks++; if ({display_on, invert, seg_remap, com_scan_rev} !== 4'b0000) begin n_fails++; $display("[TB] FAIL oled_rst_flags: got %b expected 0000", {display_on, invert, seg_remap, com_scan_rev}); end
        n_checks++; if (start_line !== 6'd0) begin n_fails++; $display("[TB] FAIL oled_rst_start_line: got %h expected 00", start_line); end
        n_checks++; if (wr_addr_q.size() != 0) begin n_fails++; $display("[TB] FAIL oled_rst_no_write: got %0d writes expected 0", wr_addr_q.size()); end
        clear_log();
    endtask

    task automatic test_col_page_cmds();
        logic [9:0] exp_a [5];
        logic [7:0] exp_d [5];
        exp_a = '{10'h000, 10'h035, 10'h136, 10'h17F, 10'h100};
        exp_d = '{8'h77, 8'h88, 8'h99, 8'hAB, 8'hCD};
        send_byte(8'h77, 1'b1);
        send_byte(8'hAF, 1'b0);
        n_checks++; if (display_on !== 1'b1) begin n_fails++; $display("[TB] FAIL post_rst_opcode: got %b expected 1", display_on); end
        send_byte(8'h13, 1'b0); send_byte(8'h05, 1'b0);
        send_byte(8'h88, 1'b1);
        send_byte(8'hB2, 1'b0);
        send_byte(8'h99, 1'b1);
        send_byte(8'h1F, 1'b0);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        n_checks++; if (wr_addr_q.size() != 5) begin n_fails++; $display("[TB] FAIL colpage_wr_count: got %0d expected 5", wr_addr_q.size()); end
        for (int i = 0; i < 5; i++) if (i < wr_addr_q.size()) begin
            n_checks++;
            if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== exp_d[i]) begin
                n_fails++; $display("[TB] FAIL colpage_wr%0d: got %h/%h expected %h/%h", i, wr_addr_q[i], wr_data_q[i], exp_a[i], exp_d[i]);
            end
        end
        clear_log();
    endtask

    // Scenario sequence; later tests rely on the pointer state left behind
    // by earlier ones, so the order matters.
    initial begin
        rst             = 1'b0;
        spi_if.ss       = 1'b1;
        spi_if.scl      = 1'b0;
        spi_if.mosi     = 1'b0;
        spi_if.dc       = 1'b0;
        spi_if.oled_rst = 1'b1;
        test_reset();
        test_page_mode_data();
        test_addr_window();
        test_contrast_flags();
        test_skip();
        test_partial_byte();
        test_data_during_arg_skip();
        test_oled_reset();
        test_col_page_cmds();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
